// File: rtl/key_entry_fsm.sv
// Keypad front end for the BCD calculator: input sync, press detection, operand/operator assembly
// and a valid/ready request to the ALU. Define KEYENTRY_DEBOUNCE_EN to enable the debouncer.
module key_entry_fsm #(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [3:0]            BCDKey,
    input  logic                  KeyRead,
    input  logic [4*DIGITS-1:0]   result_in,
    input  logic                  calc_ready,
    output logic                  calc_valid,
    output logic [4*DIGITS-1:0]   operand_a,
    output logic [4*DIGITS-1:0]   operand_b,
    output logic [1:0]            op_code,
    output logic [4*DIGITS-1:0]   display,
    output logic                  key_event,
    output logic [1:0]            state
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        REQUEST = 2'd2,
        DONE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers
    // ------------------------------------------------------------------
    logic [3:0] code_meta_q, code_s_q;
    logic       key_meta_q, key_s_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            code_meta_q <= '0;
            code_s_q    <= '0;
            key_meta_q  <= 1'b0;
            key_s_q     <= 1'b0;
        end else begin
            code_meta_q <= BCDKey;
            code_s_q    <= code_meta_q;
            key_meta_q  <= KeyRead;
            key_s_q     <= key_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Press detection
    // ------------------------------------------------------------------
    logic       key_event_q, key_event_d;
    logic [3:0] code_q, code_d;

`ifdef KEYENTRY_DEBOUNCE_EN
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           latched_q, latched_d;
    logic [3:0]     code_prev_q;

    // One counter serves both phases: stable-press while unlatched, stable-release while latched.
    always_comb begin
        db_cnt_d    = db_cnt_q;
        latched_d   = latched_q;
        key_event_d = 1'b0;
        code_d      = code_q;
        if (!latched_q) begin
            if (key_s_q && (code_s_q == code_prev_q)) begin
                if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    key_event_d = 1'b1;
                    code_d      = code_s_q;
                    latched_d   = 1'b1;
                    db_cnt_d    = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DBW'(1);
                end
            end else begin
                db_cnt_d = '0;
            end
        end else begin
            if (!key_s_q) begin
                if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    latched_d = 1'b0;
                    db_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DBW'(1);
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            db_cnt_q    <= '0;
            latched_q   <= 1'b0;
            code_prev_q <= '0;
        end else begin
            db_cnt_q    <= db_cnt_d;
            latched_q   <= latched_d;
            code_prev_q <= code_s_q;
        end
    end
`else
    logic key_prev_q;

    always_comb begin
        key_event_d = key_s_q & ~key_prev_q;
        code_d      = key_event_d ? code_s_q : code_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) key_prev_q <= 1'b0;
        else       key_prev_q <= key_s_q;
    end
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            key_event_q <= 1'b0;
            code_q      <= '0;
        end else begin
            key_event_q <= key_event_d;
            code_q      <= code_d;
        end
    end

    // ------------------------------------------------------------------
    // Entry state machine
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [1:0]      op_q, op_d;
    logic            valid_q, valid_d;

    logic is_digit, is_eq, is_clr, is_op;
    logic [W-1:0] digit_ext;

    always_comb begin
        is_digit  = key_event_q && (code_q < 4'd10);
        is_eq     = key_event_q && (code_q == 4'd10);
        is_clr    = key_event_q && (code_q == 4'd11);
        is_op     = key_event_q && (code_q >= 4'd12);
        digit_ext = {{(W-4){1'b0}}, code_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        op_d    = op_q;
        valid_d = valid_q;
        if (is_clr) begin
            state_d = ENTER_A;
            a_d     = '0;
            b_d     = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            op_d    = '0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ENTER_A: begin
                    if (is_digit && (cnt_a_q < CW'(DIGITS))) begin
                        a_d     = {a_q[W-5:0], code_q};
                        cnt_a_d = cnt_a_q + CW'(1);
                    end else if (is_op) begin
                        op_d    = code_q[1:0];
                        b_d     = '0;
                        cnt_b_d = '0;
                        state_d = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit && (cnt_b_q < CW'(DIGITS))) begin
                        b_d     = {b_q[W-5:0], code_q};
                        cnt_b_d = cnt_b_q + CW'(1);
                    end else if (is_op && (cnt_b_q == '0)) begin
                        op_d = code_q[1:0];
                    end else if (is_eq) begin
                        valid_d = 1'b1;
                        state_d = REQUEST;
                    end
                end
                REQUEST: begin
                    if (calc_ready) begin
                        a_d     = result_in;
                        cnt_a_d = CW'(DIGITS);
                        valid_d = 1'b0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (is_digit) begin
                        a_d     = digit_ext;
                        cnt_a_d = CW'(1);
                        state_d = ENTER_A;
                    end else if (is_op) begin
                        op_d    = code_q[1:0];
                        b_d     = '0;
                        cnt_b_d = '0;
                        state_d = ENTER_B;
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        unique case (state_q)
            ENTER_B: display = (cnt_b_q != '0) ? b_q : a_q;
            REQUEST: display = b_q;
            default: display = a_q;
        endcase
    end

    assign calc_valid = valid_q;
    assign operand_a  = a_q;
    assign operand_b  = b_q;
    assign op_code    = op_q;
    assign key_event  = key_event_q;
    assign state      = state_q;

endmodule

// File: tb/tb_key_entry_fsm.sv
// Directed bench for key_entry_fsm (DIGITS=4, DEBOUNCE_CYCLES=4); expectations follow the
// build configuration (KEYENTRY_DEBOUNCE_EN selects debounced press timing).
module tb_key_entry_fsm;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DB     = 4;
`ifdef KEYENTRY_DEBOUNCE_EN
    localparam int unsigned LAT       = 2 + DB;
    localparam int unsigned GLITCH_EV = 0;
`else
    localparam int unsigned LAT       = 3;
    localparam int unsigned GLITCH_EV = 1;
`endif

    logic                  CLK;
    logic                  RESET;
    logic [3:0]            BCDKey;
    logic                  KeyRead;
    logic [4*DIGITS-1:0]   result_in;
    logic                  calc_ready;
    logic                  calc_valid;
    logic [4*DIGITS-1:0]   operand_a;
    logic [4*DIGITS-1:0]   operand_b;
    logic [1:0]            op_code;
    logic [4*DIGITS-1:0]   display;
    logic                  key_event;
    logic [1:0]            state;

    key_entry_fsm #(.DIGITS(DIGITS), .DEBOUNCE_CYCLES(DB)) dut (
        .CLK(CLK), .RESET(RESET), .BCDKey(BCDKey), .KeyRead(KeyRead),
        .result_in(result_in), .calc_ready(calc_ready), .calc_valid(calc_valid),
        .operand_a(operand_a), .operand_b(operand_b), .op_code(op_code),
        .display(display), .key_event(key_event), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;
    int ev_cnt     = 0;
    int e0;

    always @(posedge CLK) if (key_event === 1'b1) ev_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        int start;
        BCDKey  = code;
        KeyRead = 1'b0;
        tick(3);
        start   = ev_cnt;
        KeyRead = 1'b1;
        tick(12);
        KeyRead = 1'b0;
        tick(12);
        chk("one_event_per_press", ev_cnt - start, 1);
    endtask

    task automatic handshake(input logic [15:0] res);
        result_in  = res;
        calc_ready = 1'b1;
        tick(1);
        calc_ready = 1'b0;
        result_in  = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   calc_valid, 0);
        chk({tag, "_a"},       operand_a,  0);
        chk({tag, "_b"},       operand_b,  0);
        chk({tag, "_op"},      op_code,    0);
        chk({tag, "_display"}, display,    0);
        chk({tag, "_event"},   key_event,  0);
        chk({tag, "_state"},   state,      0);
    endtask

    initial begin
        RESET = 1'b1; BCDKey = '0; KeyRead = 1'b0; result_in = '0; calc_ready = 1'b0;
        tick(2);
        chk_all_zero("reset");
        RESET = 1'b0;
        tick(2);

        // Basic calculation 12 + 3
        press(4'd1); press(4'd2);
        chk("t1_a_entry", operand_a, 16'h0012);
        chk("t1_disp_a", display, 16'h0012);
        press(4'd12);
        chk("t1_state_b", state, 1);
        chk("t1_disp_b_empty", display, 16'h0012);
        press(4'd3);
        chk("t1_disp_b", display, 16'h0003);
        press(4'd10);
        chk("t1_valid", calc_valid, 1);
        chk("t1_a", operand_a, 16'h0012);
        chk("t1_b", operand_b, 16'h0003);
        chk("t1_op", op_code, 0);
        chk("t1_state_req", state, 2);
        chk("t1_disp_req", display, 16'h0003);
        handshake(16'h0015);
        chk("t1_valid_drop", calc_valid, 0);
        chk("t1_state_done", state, 3);
        chk("t1_disp_result", display, 16'h0015);

        // calc_ready without a pending request does nothing
        result_in = 16'h7777; calc_ready = 1'b1;
        tick(3);
        calc_ready = 1'b0; result_in = '0;
        chk("stray_ready_a", operand_a, 16'h0015);
        chk("stray_ready_state", state, 3);

        // Chained operation from DONE
        press(4'd13); press(4'd2); press(4'd10);
        chk("t5_a", operand_a, 16'h0015);
        chk("t5_op", op_code, 1);
        chk("t5_b", operand_b, 16'h0002);
        chk("t5_valid", calc_valid, 1);
        handshake(16'h0013);
        chk("t5_done", state, 3);
        press(4'd4);
        chk("t5_new_a", operand_a, 16'h0004);
        chk("t5_state", state, 0);

        // Operator replacement only before the first B digit
        press(4'd12); press(4'd14); press(4'd15);
        chk("op_replace", op_code, 3);
        press(4'd6); press(4'd12);
        chk("op_locked", op_code, 3);
        chk("op_b", operand_b, 16'h0006);

        press(4'd11);
        chk("clear_state", state, 0);
        chk("clear_a", operand_a, 0);
        chk("clear_b", operand_b, 0);
        chk("clear_op", op_code, 0);

        // Digit overflow and '=' ignored in ENTER_A
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        chk("t3_a_full", operand_a, 16'h1234);
        press(4'd10);
        chk("t3_eq_ignored", state, 0);

        // Keys ignored in REQUEST
        press(4'd12); press(4'd9); press(4'd10);
        tick(20);
        chk("t4_wait_valid", calc_valid, 1);
        press(4'd9); press(4'd12);
        chk("t4_b_hold", operand_b, 16'h0009);
        chk("t4_a_hold", operand_a, 16'h1234);
        chk("t4_valid_hold", calc_valid, 1);
        chk("t4_state_hold", state, 2);

        // Clear coinciding with calc_ready, with exact press latency
        BCDKey = 4'd11; KeyRead = 1'b0;
        tick(3);
        KeyRead = 1'b1;
        tick(LAT - 1);
        chk("latency_early", key_event, 0);
        tick(1);
        chk("latency_hit", key_event, 1);
        calc_ready = 1'b1; result_in = 16'h9999;
        tick(1);
        calc_ready = 1'b0; result_in = '0;
        chk("clr_over_ready_valid", calc_valid, 0);
        chk("clr_over_ready_state", state, 0);
        chk("clr_over_ready_a", operand_a, 0);
        chk("clr_over_ready_b", operand_b, 0);
        chk("event_single_cycle", key_event, 0);
        KeyRead = 1'b0;
        tick(12);

        // Short glitch, then long hold of '7'
        BCDKey = 4'd10;
        tick(3);
        e0 = ev_cnt;
        KeyRead = 1'b1;
        tick(3);
        KeyRead = 1'b0;
        tick(12);
        chk("t2_glitch_events", ev_cnt - e0, GLITCH_EV);
        chk("t2_glitch_state", state, 0);
        BCDKey = 4'd7;
        tick(3);
        e0 = ev_cnt;
        KeyRead = 1'b1;
        tick(100);
        chk("t2_hold_events", ev_cnt - e0, 1);
        chk("t2_hold_a", operand_a, 16'h0007);
        KeyRead = 1'b0;
        tick(12);
        chk("t2_release_events", ev_cnt - e0, 1);

        // Reset during press detection
        BCDKey = 4'd5;
        tick(3);
        e0 = ev_cnt;
        KeyRead = 1'b1;
        tick(LAT - 1);
        RESET = 1'b1;
        #1;
        chk_all_zero("t6_mid_press");
        KeyRead = 1'b0;
        tick(2);
        RESET = 1'b0;
        tick(20);
        chk("t6_no_event", ev_cnt - e0, 0);
        chk("t6_a", operand_a, 0);

        // Reset while a request is outstanding, asserted mid-cycle
        press(4'd1); press(4'd12); press(4'd2); press(4'd10);
        chk("t6_req_valid", calc_valid, 1);
        #3;
        RESET = 1'b1;
        #1;
        chk_all_zero("t6_async");
        tick(2);
        RESET = 1'b0;
        tick(2);
        chk("t6_post_state", state, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
